// File: rtl/demux1_2_32_hs.sv
// ---------------------------------------------------------------------------
// demux1_2_32_hs
//
// Handshaked 1-to-2 router. Each incoming word carries a Select bit that names
// its destination port (0 or 1). Words are held in a two-entry buffer made of
// a main register (the head, driving the outputs) and a skid register (which
// catches a word accepted while the head is stalled). This gives one cycle of
// latency and one word per cycle when neither sink pushes back.
//
// Ordering is strict FIFO across both ports: a head word stalled on one port
// also blocks any queued word bound for the other port.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     input word (W bits)
//   Select      destination of in_data: 0 -> port 0, 1 -> port 1
//   in_valid    in_data/Select valid
//   in_ready    block can accept a word (depends only on registered state)
//   out0_data   port 0 word, forced to 0 when port 0 is not the head destination
//   out0_valid  port 0 word valid
//   out0_ready  port 0 sink accepts
//   out1_data   port 1 word, forced to 0 when port 1 is not the head destination
//   out1_valid  port 1 word valid
//   out1_ready  port 1 sink accepts
//   cnt0        completed port-0 transfers, wraps modulo 2^CNT_W
//   cnt1        completed port-1 transfers, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module demux1_2_32_hs #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             Select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Buffer state
    logic [W-1:0] main_data_reg, main_data_next;
    logic         main_sel_reg,  main_sel_next;
    logic         main_valid_reg, main_valid_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         skid_sel_reg,  skid_sel_next;
    logic         skid_valid_reg, skid_valid_next;

    // Per-port views, indexed by port number
    logic [1:0]       port_valid;
    logic [1:0]       port_ready;
    logic [1:0]       port_fire;
    logic [W-1:0]     port_data [2];
    logic [CNT_W-1:0] cnt_reg   [2];

    logic in_fire;
    logic out_fire;

    // The skid register is the only thing that can refuse input, so in_ready
    // comes straight from a flop and never sees the sinks' ready signals.
    assign in_ready   = !skid_valid_reg;
    assign in_fire    = in_valid & in_ready;
    assign port_ready = {out1_ready, out0_ready};
    assign out_fire   = |port_fire;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_valid[gi] = main_valid_reg & (main_sel_reg == (gi == 1));
            assign port_fire[gi]  = port_valid[gi] & port_ready[gi];
            assign port_data[gi]  = port_valid[gi] ? main_data_reg : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (port_fire[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign out0_valid = port_valid[0];
    assign out1_valid = port_valid[1];
    assign out0_data  = port_data[0];
    assign out1_data  = port_data[1];
    assign cnt0       = cnt_reg[0];
    assign cnt1       = cnt_reg[1];

    // Next-state selection for the two-entry buffer
    always_comb begin
        main_data_next  = main_data_reg;
        main_sel_next   = main_sel_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_sel_next   = skid_sel_reg;
        skid_valid_next = skid_valid_reg;

        if (!main_valid_reg) begin
            // Skid is always empty here, so a new word goes straight to the head.
            if (in_fire) begin
                main_data_next  = in_data;
                main_sel_next   = Select;
                main_valid_next = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_valid_reg) begin
                // in_ready was low, so no new word competes with the skid entry.
                main_data_next  = skid_data_reg;
                main_sel_next   = skid_sel_reg;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                main_data_next  = in_data;
                main_sel_next   = Select;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            // Head stalled: park the new word behind it.
            skid_data_next  = in_data;
            skid_sel_next   = Select;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_reg  <= '0;
            main_sel_reg   <= 1'b0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_sel_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_data_reg  <= main_data_next;
            main_sel_reg   <= main_sel_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_sel_reg   <= skid_sel_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

endmodule
